// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ sprite drawers onto one VGA pixel port.
// Define ARB_TIMEOUT_EN to add a hold watchdog that force-releases a grant after MAX_HOLD cycles.
module sprite_draw_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    done,
    input  logic [NUM_REQ*10-1:0] x_in,
    input  logic [NUM_REQ*10-1:0] y_in,
    input  logic [NUM_REQ*3-1:0]  color_in,
    input  logic [NUM_REQ-1:0]    we_in,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [9:0]            x,
    output logic [9:0]            y,
    output logic [2:0]            color,
    output logic                  writeEn,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int unsigned PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 8192) begin : g_bad_cfg
        $error("sprite_draw_arbiter: NUM_REQ or MAX_HOLD out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [PW-1:0]      g_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      next_ptr;
    logic [PW-1:0]      win;
    logic               found;
    logic               user_rel;
    logic               release_now;

    logic [9:0] x_arr [NUM_REQ];
    logic [9:0] y_arr [NUM_REQ];
    logic [2:0] c_arr [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            x_arr[i] = x_in[i*10 +: 10];
            y_arr[i] = y_in[i*10 +: 10];
            c_arr[i] = color_in[i*3 +: 3];
        end
    end

    // First set request at or above rr_ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = k + 32'(rr_ptr_q);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx[PW-1:0]]) begin
                win   = idx[PW-1:0];
                found = 1'b1;
            end
        end
    end

    assign next_ptr = (32'(g_q) == NUM_REQ - 1) ? '0 : g_q + 1'b1;
    assign user_rel = done[g_q] | ~req[g_q];

`ifdef ARB_TIMEOUT_EN
    logic [12:0] hold_q;
    logic        err_q;
    logic        hold_hit;

    assign hold_hit    = (hold_q == 13'(MAX_HOLD - 1));
    assign release_now = user_rel | hold_hit;
    assign timeout_err = err_q;
`else
    assign release_now = user_rel;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            g_q      <= '0;
            rr_ptr_q <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= GRANT;
                        g_q     <= win;
                        gnt_q   <= NUM_REQ'(1) << win;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
`ifdef ARB_TIMEOUT_EN
                    hold_q <= hold_q + 13'd1;
                    // Only flag the watchdog when the requester did not release on its own.
                    if (hold_hit && !user_rel) begin
                        err_q <= 1'b1;
                    end
`endif
                    if (release_now) begin
                        state_q <= RELEASE;
                        gnt_q   <= '0;
                    end
                end
                RELEASE: begin
                    state_q  <= IDLE;
                    rr_ptr_q <= next_ptr;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);

    always_comb begin
        x       = '0;
        y       = '0;
        color   = '0;
        writeEn = 1'b0;
        if (state_q == GRANT) begin
            x       = x_arr[g_q];
            y       = y_arr[g_q];
            color   = c_arr[g_q];
            writeEn = we_in[g_q];
        end
    end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Self-checking bench for sprite_draw_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_sprite_draw_arbiter;
    localparam int N  = 4;
    localparam int MH = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic [N-1:0]  req      = '0;
    logic [N-1:0]  done     = '0;
    logic [N*10-1:0] x_in   = '0;
    logic [N*10-1:0] y_in   = '0;
    logic [N*3-1:0]  color_in = '0;
    logic [N-1:0]  we_in    = '0;
    logic [N-1:0]  gnt;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [2:0]    color;
    logic          writeEn;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    sprite_draw_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .done       (done),
        .x_in       (x_in),
        .y_in       (y_in),
        .color_in   (color_in),
        .we_in      (we_in),
        .gnt        (gnt),
        .x          (x),
        .y          (y),
        .color      (color),
        .writeEn    (writeEn),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: who owns the port, how many blocked cycles remain after a grant, where the search starts.
    int m_owner = -1;
    int m_gap   = 0;
    int m_next  = 0;
    int m_held  = 0;
    bit m_err   = 1'b0;

    function automatic void m_end_grant();
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1;
            m_gap   = 0;
            m_next  = 0;
            m_held  = 0;
            m_err   = 1'b0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (done[m_owner] || !req[m_owner]) begin
                m_end_grant();
            end else if (TO_EN && m_held == MH) begin
                m_err = 1'b1;
                m_end_grant();
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req[(m_next + k) % N]) begin
                    m_owner = (m_next + k) % N;
                    m_held  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int eg, ex, ey, ec, ew, eb;
            eg = (m_owner >= 0) ? (1 << m_owner) : 0;
            ex = (m_owner >= 0) ? 32'(x_in[m_owner*10 +: 10]) : 0;
            ey = (m_owner >= 0) ? 32'(y_in[m_owner*10 +: 10]) : 0;
            ec = (m_owner >= 0) ? 32'(color_in[m_owner*3 +: 3]) : 0;
            ew = (m_owner >= 0) ? 32'(we_in[m_owner]) : 0;
            eb = (m_owner >= 0 || m_gap > 0) ? 1 : 0;
            chk("m_gnt", 32'(gnt), eg);
            chk("m_x", 32'(x), ex);
            chk("m_y", 32'(y), ey);
            chk("m_color", 32'(color), ec);
            chk("m_writeEn", 32'(writeEn), ew);
            chk("m_busy", 32'(busy), eb);
            chk("m_timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req      = '0;
        done     = '0;
        we_in    = '1;
        x_in     = 40'h12345_6789A;
        y_in     = '0;
        color_in = '0;
        @(negedge clk);
        reset_n = 1'b0;
        chk_on  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_writeEn", 32'(writeEn), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        we_in   = '0;
        x_in    = '0;
        step();
    endtask

    bit drop [N];

    task automatic rand_drive();
        int unsigned r;
        for (int i = 0; i < N; i++) begin
            done[i] = 1'b0;
            if (drop[i]) begin
                req[i]  = 1'b0;
                drop[i] = 1'b0;
            end else if (gnt[i]) begin
                r = $urandom_range(0, 99);
                if (r < 15) begin
                    done[i] = 1'b1;
                    drop[i] = 1'b1;
                end else if (r < 18) begin
                    req[i] = 1'b0;
                end
            end else begin
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                if ($urandom_range(0, 9) == 0) done[i] = 1'b1;
            end
        end
        we_in    = 4'($urandom);
        x_in     = 40'({$urandom, $urandom});
        y_in     = 40'({$urandom, $urandom});
        color_in = 12'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w, idx, last;

        // Single requester, full path through GRANT and RELEASE.
        do_reset();
        req = 4'b0001;
        x_in[9:0] = 10'd123;
        y_in[9:0] = 10'd45;
        color_in[2:0] = 3'd5;
        we_in = 4'b0001;
        step();
        chk("d1_gnt", 32'(gnt), 1);
        chk("d1_busy", 32'(busy), 1);
        chk("d1_x", 32'(x), 123);
        chk("d1_y", 32'(y), 45);
        chk("d1_color", 32'(color), 5);
        chk("d1_writeEn", 32'(writeEn), 1);
        repeat (3) step();
        done = 4'b0001;
        step();
        done = '0;
        req  = '0;
        chk("d1_rel_gnt", 32'(gnt), 0);
        chk("d1_rel_busy", 32'(busy), 1);
        chk("d1_rel_x", 32'(x), 0);
        step();
        chk("d1_idle_busy", 32'(busy), 0);

        // Mux ignores other slices; pixel on the done cycle is still written.
        req   = 4'b0100;
        we_in = 4'b1111;
        x_in  = {10'd0, 10'd37, 10'd100, 10'd0};
        step();
        chk("d2_gnt", 32'(gnt), 4);
        chk("d2_x", 32'(x), 37);
        chk("d2_writeEn", 32'(writeEn), 1);
        x_in[29:20] = 10'd5;
        done = 4'b0100;
        #1;
        chk("d2_done_x", 32'(x), 5);
        chk("d2_done_writeEn", 32'(writeEn), 1);
        step();
        done = '0;
        req  = '0;
        chk("d2_rel_gnt", 32'(gnt), 0);
        chk("d2_rel_x", 32'(x), 0);
        chk("d2_rel_writeEn", 32'(writeEn), 0);
        step();
        req = 4'b1011;
        step();
        chk("d2_ptr3_gnt", 32'(gnt), 8);
        done = 4'b1000;
        step();
        done = '0;
        req  = '0;
        step();

        // Round-robin rotation with everyone requesting.
        do_reset();
        req  = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (gnt == '0 && w < 20) begin
                step();
                w++;
            end
            chk("rr_seen", 32'(gnt != '0), 1);
            idx = -1;
            for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
            chk("rr_order", 32'(idx), 32'(k % N));
            if (k > 0) chk("rr_gap", 32'(cyc - last), 7);
            last = cyc;
            repeat (4) step();
            done = gnt;
            step();
            done = '0;
        end
        req = '0;
        step();

        // Asynchronous reset mid-grant.
        do_reset();
        we_in = '1;
        x_in[19:10] = 10'd77;
        req = 4'b0010;
        step();
        chk("ar_gnt", 32'(gnt), 2);
        chk("ar_x", 32'(x), 77);
        step();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_low_gnt", 32'(gnt), 0);
        chk("ar_low_writeEn", 32'(writeEn), 0);
        chk("ar_low_busy", 32'(busy), 0);
        chk("ar_low_x", 32'(x), 0);
        req = 4'b1000;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        step();
        chk("ar_after_gnt", 32'(gnt), 8);
        done = 4'b1000;
        step();
        done = '0;
        req  = '0;
        step();

`ifdef ARB_TIMEOUT_EN
        do_reset();
        req = 4'b0110;
        step();
        chk("to_gnt", 32'(gnt), 2);
        n = 0;
        while (gnt == 4'b0010 && n < 100) begin
            n++;
            step();
        end
        chk("to_len", 32'(n), 16);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_rel_gnt", 32'(gnt), 0);
        step();
        step();
        chk("to_next_gnt", 32'(gnt), 4);
        repeat (5) step();
        chk("to_sticky", 32'(timeout_err), 1);
        done = 4'b0100;
        step();
        done = '0;
        req  = '0;
        step();
        step();
`else
        do_reset();
        req = 4'b0010;
        repeat (40) step();
        chk("nt_gnt", 32'(gnt), 2);
        chk("nt_err", 32'(timeout_err), 0);
        req = '0;
        step();
        step();
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < N; i++) drop[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rand_drive();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
